// File: rtl/cia_bus_pkg.sv
// Shared constants and state type for the CIA-style register bus slave.
// Imported by the responder and its E-clock helpers.
package cia_bus_pkg;

  localparam int CIA_ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_FETCH = 3'd1,
    RD_DRIVE = 3'd2,
    WR_WAIT  = 3'd3,
    HOLD     = 3'd4
  } cia_state_e;

  localparam logic [CIA_ADDR_W-1:0] REG_CTRL   = 4'h0;
  localparam logic [CIA_ADDR_W-1:0] REG_STATUS = 4'h1;
  localparam logic [CIA_ADDR_W-1:0] REG_DATA   = 4'h2;
  localparam logic [CIA_ADDR_W-1:0] REG_CMD    = 4'h3;

endpackage

// File: rtl/e_edge_detect.sv
// Rise/fall detector for a synchronized E clock.
// A rise only counts once E has been seen low since reset.
module e_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic e_i,
  output logic e_rise_o,
  output logic e_fall_o
);

  logic e_d_q;
  logic armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_d_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      e_d_q   <= e_i;
      armed_q <= armed_q | ~e_i;
    end
  end

  assign e_rise_o = e_i & ~e_d_q & armed_q;
  assign e_fall_o = ~e_i & e_d_q;

endmodule

// File: rtl/cia_bus_responder.sv
// 6520/8520-style slave cycle on the synchronized CIA bus:
// register strobes, read data drive and post-E hold.
module cia_bus_responder
  import cia_bus_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_W      = CIA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  input  logic              _cs,
  input  logic              reg_decode,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  input  logic [7:0]        reg_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd,
  output logic              reg_wr,
  output logic [7:0]        reg_wdata,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic              busy
);

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

  cia_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        dout_q, dout_d;
  logic              oe_q, oe_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              e_rise, e_fall;
  logic              sel;
  logic              rd, wr;

  e_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .e_i      (e),
    .e_rise_o (e_rise),
    .e_fall_o (e_fall)
  );

  assign sel = ~_cs & reg_decode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    cnt_d   = cnt_q;
    rd      = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        oe_d = 1'b0;
        if (e_rise && sel) begin
          addr_d = addr;
          if (rw) begin
            rd      = 1'b1;
            state_d = RD_FETCH;
          end else begin
            state_d = WR_WAIT;
          end
        end
      end
      RD_FETCH: begin
        dout_d  = reg_rdata;
        oe_d    = 1'b1;
        state_d = RD_DRIVE;
      end
      RD_DRIVE: begin
        // Level test so a very short E-high phase still ends the cycle.
        if (!e) begin
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else if (!sel) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (e_fall) begin
          if (sel) begin
            wr      = 1'b1;
            wdata_d = data_in;
            cnt_d   = HOLD_LD;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (!sel) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        oe_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Strobe cycles present the live address/data so the register
  // file sees them alongside the strobe itself.
  assign reg_addr  = rd ? addr : addr_q;
  assign reg_wdata = wr ? data_in : wdata_q;
  assign reg_rd    = rd;
  assign reg_wr    = wr;
  assign data_out  = dout_q;
  assign data_oe   = oe_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cia_bus_responder.sv
// Randomized E-cycle bench for cia_bus_responder with a
// per-period expectation model and a register file stub.
module tb_cia_bus_responder;

  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0;
  logic       _cs = 1'b1;
  logic       reg_decode = 1'b0;
  logic       rw = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] reg_rdata;
  logic [3:0] reg_addr;
  logic       reg_rd, reg_wr, data_oe, busy;
  logic [7:0] reg_wdata, data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] rf      [16];
  logic [7:0] ref_mem [16];
  logic [7:0] exp_dout;

  cia_bus_responder #(.HOLD_CYCLES(H), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .e          (e),
    ._cs        (_cs),
    .reg_decode (reg_decode),
    .rw         (rw),
    .addr       (addr),
    .data_in    (data_in),
    .reg_rdata  (reg_rdata),
    .reg_addr   (reg_addr),
    .reg_rd     (reg_rd),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr) rf[reg_addr] <= reg_wdata;
    reg_rdata <= rf[reg_addr];
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // kind: 0 read, 1 write, 2 aborted read, 3 aborted write, 4 unselected
  // a: first deselected cycle of an abort, counted from the E rise.
  task automatic run_period(int kind, int high, int low, int a,
                            logic [3:0] ad, logic [7:0] wd, bit use_cs);
    int p = high + low;
    bit sel, is_rd, ex_rd, ex_wr, ex_oe, ex_busy;
    logic [7:0] rdv;
    rdv   = ref_mem[ad];
    is_rd = (kind == 0) || (kind == 2);
    for (int k = 0; k < p; k++) begin
      @(posedge clk);
      #1;
      sel        = (kind == 4) ? 1'b0 : (kind >= 2 && k >= a) ? 1'b0 : 1'b1;
      e          = (k < high);
      _cs        = use_cs ? ~sel : 1'b0;
      reg_decode = use_cs ? 1'b1 : sel;
      rw         = is_rd;
      addr       = (k == 0) ? ad : 4'($urandom);
      data_in    = wd;
      ex_rd      = is_rd && (k == 0);
      ex_wr      = (kind == 1) && (k == high);
      case (kind)
        0:       ex_oe = (k >= 2) && (k <= high + H);
        2:       ex_oe = (k >= 2) && (k <= a);
        default: ex_oe = 1'b0;
      endcase
      case (kind)
        0, 1:    ex_busy = (k >= 1) && (k <= high + H);
        2, 3:    ex_busy = (k >= 1) && (k <= a);
        default: ex_busy = 1'b0;
      endcase
      if (is_rd && k == 2) exp_dout = rdv;
      @(negedge clk);
      chk("reg_rd", reg_rd, ex_rd);
      chk("reg_wr", reg_wr, ex_wr);
      chk("data_oe", data_oe, ex_oe);
      chk("busy", busy, ex_busy);
      chk("data_out", data_out, exp_dout);
      if (ex_rd) chk("rd_addr", reg_addr, ad);
      if (ex_wr) begin
        chk("wr_addr", reg_addr, ad);
        chk("wr_data", reg_wdata, wd);
      end
    end
    if (kind == 1) ref_mem[ad] = wd;
  endtask

  initial begin
    int kind, high, low, a;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      rf[i]      = ref_mem[i];
    end
    ref_mem[13] = 8'h5A;
    rf[13]      = 8'h5A;
    exp_dout    = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", reg_rd, 0);
    chk("rst_wr", reg_wr, 0);
    chk("rst_oe", data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_period(0, 5, 5, 0, 4'hD, 8'h00, 1'b1);
    run_period(1, 5, 5, 0, 4'h3, 8'hC3, 1'b1);
    run_period(2, 6, 4, 3, 4'hD, 8'h00, 1'b1);
    run_period(3, 5, 5, 3, 4'h6, 8'h99, 1'b0);
    run_period(4, 5, 5, 0, 4'h2, 8'h11, 1'b1);
    run_period(0, 5, 5, 0, 4'h3, 8'h00, 1'b1);
    run_period(1, 5, 5, 0, 4'h3, 8'h77, 1'b1);
    run_period(0, 4, 4, 0, 4'h3, 8'h00, 1'b0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      high = $urandom_range(3, 8);
      low  = $urandom_range(H + 2, 8);
      a    = (kind == 2) ? $urandom_range(2, high - 1)
                         : $urandom_range(1, high - 1);
      run_period(kind, high, low, a, 4'($urandom), 8'($urandom),
                 1'($urandom));
    end

    // Reset while a read is driving the bus.
    @(posedge clk);
    #1;
    e = 1'b1; _cs = 1'b0; reg_decode = 1'b1; rw = 1'b1; addr = 4'h7;
    repeat (3) @(posedge clk);
    #1;
    chk("oe_before_rst", data_oe, 1);
    rst = 1'b1;
    #1;
    exp_dout = 8'h00;
    chk("oe_async_rst", data_oe, 0);
    chk("busy_async_rst", busy, 0);
    chk("dout_async_rst", data_out, 0);
    chk("rd_async_rst", reg_rd, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rd_after_rst", reg_rd, 0);
      chk("busy_after_rst", busy, 0);
      chk("oe_after_rst", data_oe, 0);
    end
    e = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_e_low", busy, 0);
    end
    run_period(0, 5, 5, 0, 4'h7, 8'h00, 1'b1);
    run_period(1, 5, 5, 0, 4'h7, 8'h3C, 1'b0);
    run_period(0, 5, 5, 0, 4'h7, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cia_bus_responder.md
Name: cia_bus_responder

Overview:
- Target-side CIA-style register bus responder for the A500 SD controller.
- Takes the CIA bus signals after they have been synchronized into the local clock domain (E clock, chip select, register decode, R/W, address, write data) and runs a 6520/8520-style slave cycle framed by E.
- Issues one-cycle read and write strobes to the local register file.
- Drives read data onto the bus with a registered output enable and a programmable hold after E falls.

Parameters:
- HOLD_CYCLES, 2, number of clk cycles data_oe stays asserted after the E falling edge is detected (1..15); must be shorter than the E-low time.
- ADDR_W, 4, register address width.

Ports:
- clk  in  1  destination clock, same as the synchronizer clock.
- rst  in  1  asynchronous, active-high reset.
- e  in  1  synchronized E clock.
- _cs  in  1  synchronized chip select, active low.
- reg_decode  in  1  synchronized register address strobe, active high.
- rw  in  1  synchronized R/_W; 1 = read.
- addr  in  ADDR_W  synchronized register address.
- data_in  in  8  synchronized bus write data.
- reg_rdata  in  8  register file read data, valid 1 clk after reg_rd.
- reg_addr  out  ADDR_W  latched register address.
- reg_rd  out  1  one-clk read strobe.
- reg_wr  out  1  one-clk write strobe.
- reg_wdata  out  8  latched write data, valid while reg_wr = 1.
- data_out  out  8  bus read data.
- data_oe  out  1  bus data output enable.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst = 1): every output is 0, the state is IDLE, and e_d = 0. data_oe drops with no clock edge needed.
- Edge detect: e_d is registered from e.
  - e_rise = e & !e_d.
  - e_fall = !e & e_d.
  - sel = !_cs & reg_decode.
- IDLE:
  - data_oe = 0.
  - On e_rise & sel:
    - reg_addr <= addr.
    - If rw = 1: reg_rd = 1 for this clk, then go to RD_FETCH.
    - If rw = 0: go to WR_WAIT.
  - e_rise without sel is ignored.
- RD_FETCH (1 clk):
  - data_out <= reg_rdata.
  - data_oe <= 1.
  - Go to RD_DRIVE.
- RD_DRIVE:
  - Hold data_out and data_oe.
  - On e_fall: load hold_cnt = HOLD_CYCLES - 1, go to HOLD.
  - On !sel while e = 1 (abort): data_oe <= 0 on the next clk, go to IDLE.
- WR_WAIT:
  - On e_fall & sel: reg_wdata <= data_in and reg_wr = 1 for exactly 1 clk, then load hold_cnt and go to HOLD.
  - On !sel while e = 1 (abort): go to IDLE with no reg_wr.
- HOLD:
  - data_oe keeps its value (1 after a read, 0 after a write).
  - hold_cnt decrements each clk.
  - At hold_cnt = 0: data_oe <= 0, go to IDLE.
  - A qualified e_rise during HOLD is ignored; no access starts.
- Latency:
  - reg_rd is asserted in the same clk the e_rise is seen.
  - data_oe rises 2 clks after the synchronized E rise.
  - data_oe falls HOLD_CYCLES clks after e_fall is detected.
- Accesses: at most one per E period. After an access finishes, a new access needs a fresh e_rise.
- Strobes: reg_rd and reg_wr are never high together and never longer than 1 clk.
- data_out: holds its last value when data_oe = 0.
- Reset mid-cycle: no strobe is issued. The first access after reset release requires a new e_rise; an e already high at release does not count as an edge.

Decomposition:
- Shared package cia_bus_pkg:
  - State encoding localparams: IDLE, RD_FETCH, RD_DRIVE, WR_WAIT, HOLD.
  - CIA_ADDR_W = 4.
  - CIA register offset constants.
- Sub-module: e_edge_detect (e_d register; e_rise and e_fall outputs), reusable by other E-synchronous blocks.
- Instantiated behind sync_cia_bus in the top level.

Test Plan:
- Read: E period 10 clks, _cs = 0, reg_decode = 1, rw = 1, addr = 4'hD, reg_rdata = 8'h5A → reg_rd is 1 clk in the e_rise clk with reg_addr = D. data_out = 5A and data_oe = 1 from 2 clks after the rise until 2 clks after e_fall (HOLD_CYCLES = 2).
- Write: rw = 0, addr = 4'h3, data_in = 8'hC3 stable at E fall → a single reg_wr pulse in the e_fall clk with reg_wdata = C3 and reg_addr = 3. data_oe stays 0 throughout.
- Abort read: _cs goes high 3 clks after e_rise while e = 1 → data_oe = 0 on the next clk, state returns to IDLE, busy = 0, no further strobes.
- Abort write: reg_decode = 0 before E falls → no reg_wr, return to IDLE.
- Unselected / back-to-back: e_rise with _cs = 1 gives no strobes. Two consecutive selected E cycles (read then write) give exactly one reg_rd then one reg_wr.
- Reset: assert rst during RD_DRIVE → data_oe = 0 asynchronously. Release rst while e = 1 → no access until the next e_rise.
